// File: rtl/instr_register_pkg.sv
// instr_register_pkg: shared instruction, address and scheduler types
package instr_register_pkg;
  typedef enum logic [2:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic [4:0] address_t;
  typedef enum logic [1:0] {IDLE, LOAD, FULL} sched_state_t;
  localparam int SCHED_COUNT_W = 6;
endpackage

// File: rtl/instr_reg_scheduler_if.sv
// instr_reg_scheduler_if: requester/register-file bundle; grant counters exist only with INSTR_SCHED_STATS_EN
interface instr_reg_scheduler_if;
  import instr_register_pkg::*;
  logic req0_valid, req1_valid, req0_ready, req1_ready, flush, load_en, grant_id, full;
  opcode_t req0_opcode, req1_opcode, opcode;
  operand_t req0_operand_a, req0_operand_b, req1_operand_a, req1_operand_b, operand_a, operand_b;
  address_t write_pointer;
  logic [SCHED_COUNT_W-1:0] count;
  sched_state_t state;
`ifdef INSTR_SCHED_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif
  modport master(
    output req0_valid, req1_valid, req0_opcode, req1_opcode, req0_operand_a, req0_operand_b,
           req1_operand_a, req1_operand_b, flush,
    input  req0_ready, req1_ready, load_en, write_pointer, opcode, operand_a, operand_b,
           grant_id, count, full, state
`ifdef INSTR_SCHED_STATS_EN
    , input grant_cnt0, grant_cnt1
`endif
  );
  modport slave(
    input  req0_valid, req1_valid, req0_opcode, req1_opcode, req0_operand_a, req0_operand_b,
           req1_operand_a, req1_operand_b, flush,
    output req0_ready, req1_ready, load_en, write_pointer, opcode, operand_a, operand_b,
           grant_id, count, full, state
`ifdef INSTR_SCHED_STATS_EN
    , output grant_cnt0, grant_cnt1
`endif
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter, history moves only when advance is high
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);
  logic last;
  assign grant = valid == 2'b11 ? (last ? 2'b01 : 2'b10) : valid;
  always_ff @(posedge clk)
    if (reset) last <= 1'b1;
    else if (advance) last <= grant[1];
endmodule

// File: rtl/instr_reg_scheduler.sv
// instr_reg_scheduler: arbitrates two requesters into instruction register writes; INSTR_SCHED_STATS_EN adds grant counters
module instr_reg_scheduler
  import instr_register_pkg::*;
#(
  parameter int NUM_ENTRIES = 32
) (
  input logic clk,
  input logic reset,
  instr_reg_scheduler_if.slave bus
);
  logic [1:0] valid, grant, ready;
  logic xfer, full, sel;
  address_t wp_next;
  assign valid = {bus.req1_valid, bus.req0_valid};
  rr_arbiter2 u_arb (.clk(clk), .reset(reset), .valid(valid), .advance(xfer), .grant(grant));
  assign full = bus.count == SCHED_COUNT_W'(NUM_ENTRIES);
  assign ready = (reset || full || bus.flush) ? 2'b00 : grant;
  assign xfer = |(valid & ready);
  assign sel = ready[1];
  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.full = full;
  always_ff @(posedge clk)
    if (reset) begin
      bus.state <= IDLE;
      bus.load_en <= 1'b0;
      bus.write_pointer <= '0;
      wp_next <= '0;
      bus.opcode <= ZERO;
      bus.operand_a <= '0;
      bus.operand_b <= '0;
      bus.grant_id <= 1'b0;
      bus.count <= '0;
    end else begin
      bus.load_en <= xfer;
      if (xfer) begin
        bus.write_pointer <= wp_next;
        wp_next <= wp_next == address_t'(NUM_ENTRIES - 1) ? '0 : wp_next + 1'b1;
        bus.opcode <= sel ? bus.req1_opcode : bus.req0_opcode;
        bus.operand_a <= sel ? bus.req1_operand_a : bus.req0_operand_a;
        bus.operand_b <= sel ? bus.req1_operand_b : bus.req0_operand_b;
        bus.grant_id <= sel;
        bus.count <= bus.count + 1'b1;
      end
      if (bus.flush) begin
        bus.count <= '0;
        bus.write_pointer <= '0;
        wp_next <= '0;
      end
      // the cycle that fills the last slot still shows LOAD; FULL follows
      bus.state <= bus.flush ? IDLE : xfer ? LOAD : full ? FULL : IDLE;
    end
`ifdef INSTR_SCHED_STATS_EN
  always_ff @(posedge clk)
    if (reset) begin
      bus.grant_cnt0 <= '0;
      bus.grant_cnt1 <= '0;
    end else if (xfer) begin
      if (sel) bus.grant_cnt1 <= bus.grant_cnt1 + 1'b1;
      else bus.grant_cnt0 <= bus.grant_cnt0 + 1'b1;
    end
`endif
endmodule

// File: tb/tb_instr_reg_scheduler.sv
// tb_instr_reg_scheduler: vector table, corner sequences and random traffic against a slot-level model
module tb_instr_reg_scheduler;
  import instr_register_pkg::*;
  localparam int N = 32;
  logic clk = 1'b0;
  logic reset;
  int total = 0, bad = 0;
  instr_reg_scheduler_if bus ();
  instr_reg_scheduler #(.NUM_ENTRIES(N)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int m_count, m_next, m_wp, m_last, m_gid, m_load, m_cnt0, m_cnt1;
  opcode_t m_op;
  operand_t m_a, m_b;
  sched_state_t m_state;
  typedef struct {
    logic v0, v1, fl, rs;
    opcode_t o0; operand_t a0, b0;
    opcode_t o1; operand_t a1, b1;
    logic er0, er1, eload;
    int ewp; logic egid; int ecnt;
    opcode_t eop; operand_t ea;
  } vec_t;
  vec_t vt[10];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask
  task automatic drive(input logic v0, v1, fl, rs, input opcode_t o0, input operand_t a0, b0,
                       input opcode_t o1, input operand_t a1, b1, output logic r0, r1);
    logic e0, e1, x, g;
    bus.req0_valid = v0; bus.req1_valid = v1; bus.flush = fl; reset = rs;
    bus.req0_opcode = o0; bus.req0_operand_a = a0; bus.req0_operand_b = b0;
    bus.req1_opcode = o1; bus.req1_operand_a = a1; bus.req1_operand_b = b1;
    #2;
    e0 = 0; e1 = 0;
    if (!rs && !fl && m_count < N) begin
      if (v0 && v1) begin e0 = (m_last == 1); e1 = (m_last == 0); end
      else begin e0 = v0; e1 = v1; end
    end
    r0 = bus.req0_ready; r1 = bus.req1_ready;
    chk("req0_ready", r0, e0);
    chk("req1_ready", r1, e1);
    @(posedge clk); #1;
    x = e0 | e1; g = e1;
    if (rs) begin
      m_count = 0; m_next = 0; m_wp = 0; m_last = 1; m_gid = 0; m_load = 0;
      m_op = ZERO; m_a = 0; m_b = 0; m_cnt0 = 0; m_cnt1 = 0; m_state = IDLE;
    end else begin
      m_load = x;
      if (x) begin
        m_wp = m_next; m_next = (m_next + 1) % N;
        m_op = g ? o1 : o0; m_a = g ? a1 : a0; m_b = g ? b1 : b0;
        m_gid = g; m_last = g; m_count++;
        if (g) m_cnt1 = (m_cnt1 + 1) % 65536; else m_cnt0 = (m_cnt0 + 1) % 65536;
      end
      if (fl) begin m_count = 0; m_next = 0; m_wp = 0; end
      m_state = fl ? IDLE : x ? LOAD : (m_count == N) ? FULL : IDLE;
    end
    chk("load_en", bus.load_en, m_load);
    chk("write_pointer", bus.write_pointer, m_wp);
    chk("opcode", bus.opcode, m_op);
    chk("operand_a", bus.operand_a, m_a);
    chk("operand_b", bus.operand_b, m_b);
    chk("grant_id", bus.grant_id, m_gid);
    chk("count", bus.count, m_count);
    chk("full", bus.full, m_count == N);
    chk("state", bus.state, m_state);
`ifdef INSTR_SCHED_STATS_EN
    chk("grant_cnt0", bus.grant_cnt0, m_cnt0);
    chk("grant_cnt1", bus.grant_cnt1, m_cnt1);
`endif
  endtask
  function automatic vec_t mk(logic v0, v1, fl, rs, opcode_t o0, operand_t a0, b0, opcode_t o1,
                              operand_t a1, b1, logic er0, er1, eload, int ewp, logic egid,
                              int ecnt, opcode_t eop, operand_t ea);
    mk = '{v0, v1, fl, rs, o0, a0, b0, o1, a1, b1, er0, er1, eload, ewp, egid, ecnt, eop, ea};
  endfunction
  task automatic req(input logic v0, v1, fl, rs);
    logic r0, r1;
    drive(v0, v1, fl, rs, opcode_t'($urandom_range(0, 7)), operand_t'($urandom), operand_t'($urandom),
          opcode_t'($urandom_range(0, 7)), operand_t'($urandom), operand_t'($urandom), r0, r1);
  endtask
  initial begin
    logic r0, r1;
    vt[0] = mk(0, 0, 0, 1, ZERO, 0, 0, ZERO, 0, 0, 0, 0, 0, 0, 0, 0, ZERO, 0);
    vt[1] = mk(1, 0, 0, 0, ADD, 5, 3, ZERO, 0, 0, 1, 0, 1, 0, 0, 1, ADD, 5);
    vt[2] = mk(1, 0, 0, 0, SUB, 7, 2, ZERO, 0, 0, 1, 0, 1, 1, 0, 2, SUB, 7);
    vt[3] = mk(1, 0, 0, 0, MULT, -4, 6, ZERO, 0, 0, 1, 0, 1, 2, 0, 3, MULT, -4);
    vt[4] = mk(0, 0, 0, 0, ZERO, 0, 0, ZERO, 0, 0, 0, 0, 0, 2, 0, 3, MULT, -4);
    vt[5] = mk(1, 1, 0, 1, ADD, 1, 2, SUB, 3, 4, 0, 0, 0, 0, 0, 0, ZERO, 0);
    vt[6] = mk(1, 1, 0, 0, ADD, 1, 2, SUB, 3, 4, 1, 0, 1, 0, 0, 1, ADD, 1);
    vt[7] = mk(1, 1, 0, 0, ADD, 1, 2, SUB, 3, 4, 0, 1, 1, 1, 1, 2, SUB, 3);
    vt[8] = mk(1, 1, 0, 0, ADD, 1, 2, SUB, 3, 4, 1, 0, 1, 2, 0, 3, ADD, 1);
    vt[9] = mk(1, 1, 0, 0, ADD, 1, 2, SUB, 3, 4, 0, 1, 1, 3, 1, 4, SUB, 3);
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].v0, vt[i].v1, vt[i].fl, vt[i].rs, vt[i].o0, vt[i].a0, vt[i].b0,
            vt[i].o1, vt[i].a1, vt[i].b1, r0, r1);
      chk("vec_ready0", r0, vt[i].er0);
      chk("vec_ready1", r1, vt[i].er1);
      chk("vec_load_en", bus.load_en, vt[i].eload);
      chk("vec_wp", bus.write_pointer, vt[i].ewp);
      chk("vec_gid", bus.grant_id, vt[i].egid);
      chk("vec_count", bus.count, vt[i].ecnt);
      chk("vec_opcode", bus.opcode, vt[i].eop);
      chk("vec_operand_a", bus.operand_a, vt[i].ea);
    end
    req(0, 0, 0, 1);
    for (int i = 0; i < 33; i++) begin
      drive(1, 0, 0, 0, ADD, i, i, ZERO, 0, 0, r0, r1);
      if (i < 32) chk("fill_wp", bus.write_pointer, i);
      else chk("fill_33rd_ready", r0, 0);
    end
    for (int i = 0; i < 3; i++) req(1, 0, 0, 0);
    chk("fill_full", bus.full, 1);
    chk("fill_count", bus.count, 32);
    chk("fill_state", bus.state, FULL);
    req(1, 0, 1, 0);
    chk("fill_flush_count", bus.count, 0);
    drive(1, 0, 0, 0, PASSA, 9, 9, ZERO, 0, 0, r0, r1);
    chk("fill_release_wp", bus.write_pointer, 0);
    chk("fill_release_a", bus.operand_a, 9);
    req(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) req(0, 1, 0, 0);
    drive(0, 1, 1, 0, ZERO, 0, 0, DIV, 8, 8, r0, r1);
    chk("flush_ready1", r1, 0);
    chk("flush_count", bus.count, 0);
    chk("flush_wp", bus.write_pointer, 0);
    chk("flush_load_en", bus.load_en, 0);
    req(0, 1, 0, 0);
    chk("after_flush_wp", bus.write_pointer, 0);
    chk("after_flush_load", bus.load_en, 1);
    req(1, 1, 0, 0);
    req(1, 1, 0, 1);
    chk("midreset_load_en", bus.load_en, 0);
    chk("midreset_count", bus.count, 0);
    chk("midreset_opcode", bus.opcode, ZERO);
`ifdef INSTR_SCHED_STATS_EN
    chk("midreset_cnt0", bus.grant_cnt0, 0);
    for (int i = 0; i < 5; i++) req(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) req(0, 1, 0, 0);
    chk("stats_cnt0", bus.grant_cnt0, 5);
    chk("stats_cnt1", bus.grant_cnt1, 3);
    req(0, 0, 1, 0);
    req(0, 0, 0, 0);
    chk("stats_cnt0_flush", bus.grant_cnt0, 5);
    chk("stats_cnt1_flush", bus.grant_cnt1, 3);
`endif
    for (int i = 0; i < 1500; i++)
      req($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 199) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
